// File: rtl/ttl_shiftreg_univ_sync.sv
// N-bit 74194-style universal shift register (hold / up / down / load, optional rotate)
// with a cen-qualified auto-shift sequencer that reports completion on done.
module ttl_shiftreg_univ_sync #(
    parameter int WIDTH    = 8,
    parameter bit EDGE_CEN = 1'b1,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             CR_n,
    input  logic             cen,
    input  logic [1:0]       S,
    input  logic             ROT,
    input  logic             Dsr,
    input  logic             Dsl,
    input  logic [WIDTH-1:0] D,
    input  logic             start,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] Q,
    output logic             SO_U,
    output logic             SO_D,
    output logic             busy,
    output logic             done
);

    logic             last_cen;
    logic             cen_ev;
    logic             auto_req;
    logic [1:0]       dir;
    logic [CNT_W-1:0] remain;

    // last_cen resets high so a cen held through reset release is not an edge
    assign cen_ev   = EDGE_CEN ? (cen & ~last_cen) : cen;
    assign auto_req = start & ((S == 2'b01) | (S == 2'b10));

    assign SO_U = Q[WIDTH-1];
    assign SO_D = Q[0];

    function automatic logic [WIDTH-1:0] shift_op(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] q,
        input logic             rot,
        input logic             dsr,
        input logic             dsl
    );
        logic [WIDTH-1:0] r;
        r = q;
        if (mode == 2'b01)
            r = {q[WIDTH-2:0], rot ? q[WIDTH-1] : dsr};
        else if (mode == 2'b10)
            r = {rot ? q[0] : dsl, q[WIDTH-1:1]};
        return r;
    endfunction

    always_ff @(posedge clk or negedge CR_n) begin
        if (!CR_n) begin
            Q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            remain   <= '0;
            dir      <= 2'b01;
            last_cen <= 1'b1;
        end else begin
            last_cen <= cen;
            done     <= 1'b0;
            if (!busy) begin
                if (auto_req) begin
                    // the start cycle swallows any cen event
                    dir    <= S;
                    remain <= cnt;
                    if (cnt == '0) done <= 1'b1;
                    else           busy <= 1'b1;
                end else if (cen_ev) begin
                    case (S)
                        2'b01, 2'b10: Q <= shift_op(S, Q, ROT, Dsr, Dsl);
                        2'b11:        Q <= D;
                        default:      Q <= Q;
                    endcase
                end
            end else if (cen_ev) begin
                Q      <= shift_op(dir, Q, ROT, Dsr, Dsl);
                remain <= remain - 1'b1;
                if (remain == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ttl_shiftreg_univ_sync.sv
// Bench for ttl_shiftreg_univ_sync: vector table, directed corner sequences and a
// randomized run against an arithmetic reference model (edge mode), plus a level-mode instance.
module tb_ttl_shiftreg_univ_sync;

    logic       clk = 1'b0;
    logic       CR_n = 1'b0;
    logic       cen = 1'b0;
    logic       cen_l = 1'b0;
    logic [1:0] S = 2'b00;
    logic       ROT = 1'b0, Dsr = 1'b0, Dsl = 1'b0, start = 1'b0;
    logic [7:0] D = 8'h00;
    logic [3:0] cnt = 4'h0;
    logic [7:0] Q, Q_l;
    logic       SO_U, SO_D, busy, done;
    logic       SO_U_l, SO_D_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ttl_shiftreg_univ_sync #(.WIDTH(8), .EDGE_CEN(1'b1), .CNT_W(4)) dut (
        .clk(clk), .CR_n(CR_n), .cen(cen), .S(S), .ROT(ROT), .Dsr(Dsr), .Dsl(Dsl),
        .D(D), .start(start), .cnt(cnt), .Q(Q), .SO_U(SO_U), .SO_D(SO_D),
        .busy(busy), .done(done)
    );

    ttl_shiftreg_univ_sync #(.WIDTH(8), .EDGE_CEN(1'b0), .CNT_W(4)) dut_l (
        .clk(clk), .CR_n(CR_n), .cen(cen_l), .S(S), .ROT(ROT), .Dsr(Dsr), .Dsl(Dsl),
        .D(D), .start(start), .cnt(cnt), .Q(Q_l), .SO_U(SO_U_l), .SO_D(SO_D_l),
        .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One edge-mode event: raise cen for one clk, check right after, then drop it.
    task automatic pulse();
        @(negedge clk); cen = 1'b1;
        @(negedge clk); cen = 1'b0;
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        S = 2'b11; D = v; start = 1'b0;
        pulse(); gap();
    endtask

    typedef struct {
        logic [1:0] s;
        logic       rot, dsr, dsl;
        logic [7:0] d;
        logic [7:0] exp_q;
    } vec_t;

    // reference model state
    int  mq, mrem, mdir;
    bit  mbusy, mdone, mlast;

    function automatic int do_shift(int q, int mode, bit rot, bit dsr, bit dsl);
        int inb;
        if (mode == 1) begin
            inb = rot ? (q / 128) : int'(dsr);
            return (q * 2 + inb) % 256;
        end
        inb = rot ? (q % 2) : int'(dsl);
        return q / 2 + inb * 128;
    endfunction

    initial begin
        vec_t vt[9];
        vt[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
        vt[1] = '{2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'h4B};
        vt[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81};
        vt[3] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC0};
        vt[4] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81};
        vt[5] = '{2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03};
        vt[6] = '{2'b00, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h03};
        vt[7] = '{2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h81};
        vt[8] = '{2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h40};

        // reset state
        #12;
        chk("reset_Q", Q, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        @(negedge clk); CR_n = 1'b1;

        // cen held high for 5 clk loads once
        S = 2'b11; D = 8'hA5;
        @(negedge clk); cen = 1'b1;
        repeat (5) @(negedge clk);
        chk("edge_hold_Q", Q, 8'hA5);
        D = 8'h3C;
        @(negedge clk);
        chk("edge_hold_noreload", Q, 8'hA5);
        cen = 1'b0; gap();

        // table-driven manual ops
        load(8'h00);
        for (int i = 0; i < 9; i++) begin
            S = vt[i].s; ROT = vt[i].rot; Dsr = vt[i].dsr; Dsl = vt[i].dsl; D = vt[i].d;
            @(negedge clk); cen = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_Q", i), Q, vt[i].exp_q);
            chk($sformatf("vec%0d_SO", i), {SO_U, SO_D}, {vt[i].exp_q[7], vt[i].exp_q[0]});
            cen = 1'b0; gap();
        end
        ROT = 1'b0;

        // auto shift, cnt=3, live S/D ignored during RUN
        load(8'h01);
        S = 2'b01; Dsr = 1'b0; cnt = 4'd3; start = 1'b1;
        @(negedge clk); start = 1'b0; S = 2'b11; D = 8'hFF;
        chk("auto_busy_rise", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); cen = 1'b1;
            @(negedge clk);
            chk($sformatf("auto_Q%0d", i), Q, 8'h02 << i);
            chk($sformatf("auto_busy%0d", i), busy, (i < 2) ? 1'b1 : 1'b0);
            chk($sformatf("auto_done%0d", i), done, (i == 2) ? 1'b1 : 1'b0);
            cen = 1'b0;
            @(negedge clk);
            chk($sformatf("auto_done_low%0d", i), done, 1'b0);
        end
        S = 2'b00; pulse();
        chk("auto_after_hold", Q, 8'h08);
        gap();

        // zero count: done next clk, no busy, Q unchanged
        S = 2'b10; cnt = 4'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("zero_busy", busy, 1'b0);
        chk("zero_done", done, 1'b1);
        chk("zero_Q", Q, 8'h08);
        @(negedge clk);
        chk("zero_done_low", done, 1'b0);

        // start with S=11 is ignored
        S = 2'b11; D = 8'h77; cnt = 4'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("ign_busy", busy, 1'b0);
        chk("ign_done", done, 1'b0);
        chk("ign_Q", Q, 8'h08);

        // full count 15 with no wrap
        load(8'h00);
        S = 2'b01; Dsr = 1'b1; cnt = 4'd15; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 14; i++) begin pulse(); gap(); end
        chk("full14_busy", busy, 1'b1);
        @(negedge clk); cen = 1'b1;
        @(negedge clk);
        chk("full15_busy", busy, 1'b0);
        chk("full15_done", done, 1'b1);
        chk("full15_Q", Q, 8'hFF);
        cen = 1'b0; gap();

        // async reset mid-RUN
        load(8'h01);
        S = 2'b01; Dsr = 1'b1; cnt = 4'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        pulse(); gap(); pulse(); gap();
        chk("rst_pre_Q", Q, 8'h07);
        S = 2'b11; D = 8'h5A;
        cen = 1'b1;
        #2 CR_n = 1'b0;
        #1;
        chk("rst_async_Q", Q, 8'h00);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_done", done, 1'b0);
        @(negedge clk); CR_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hold_Q", Q, 8'h00);
        chk("rst_hold_done", done, 1'b0);
        cen = 1'b0;
        @(negedge clk); cen = 1'b1;
        @(negedge clk);
        chk("rst_reedge_Q", Q, 8'h5A);
        cen = 1'b0;

        // level mode: Dsr=1 shifted in on 4 consecutive clk
        S = 2'b00; start = 1'b0;
        @(negedge clk); CR_n = 1'b0;
        @(negedge clk); CR_n = 1'b1;
        S = 2'b01; Dsr = 1'b1; ROT = 1'b0;
        cen_l = 1'b1;
        repeat (4) @(negedge clk);
        cen_l = 1'b0;
        chk("level_Q", Q_l, 8'h0F);

        // randomized run against the reference model
        S = 2'b00; cen = 1'b0;
        @(negedge clk); CR_n = 1'b0;
        @(negedge clk); CR_n = 1'b1;
        mq = 0; mrem = 0; mdir = 1; mbusy = 0; mdone = 0; mlast = 1;
        for (int n = 0; n < 600; n++) begin
            bit ev;
            cen   = $urandom_range(0, 1);
            S     = 2'($urandom);
            ROT   = ($urandom_range(0, 3) == 0);
            Dsr   = 1'($urandom);
            Dsl   = 1'($urandom);
            D     = 8'($urandom);
            start = ($urandom_range(0, 7) == 0);
            cnt   = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
            ev = cen && !mlast;
            mdone = 0;
            if (!mbusy) begin
                if (start && (S == 2'b01 || S == 2'b10)) begin
                    mdir = int'(S); mrem = int'(cnt);
                    if (mrem == 0) mdone = 1; else mbusy = 1;
                end else if (ev) begin
                    if (S == 2'b11) mq = int'(D);
                    else if (S != 2'b00) mq = do_shift(mq, int'(S), ROT, Dsr, Dsl);
                end
            end else if (ev) begin
                mq = do_shift(mq, mdir, ROT, Dsr, Dsl);
                mrem--;
                if (mrem == 0) begin mbusy = 0; mdone = 1; end
            end
            mlast = cen;
            @(negedge clk);
            chk($sformatf("rnd%0d_Q", n), Q, mq);
            chk($sformatf("rnd%0d_bd", n), {busy, done}, {mbusy, mdone});
            chk($sformatf("rnd%0d_SO", n), {SO_U, SO_D}, {mq[7], mq[0]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
